// File: rtl/fpu_issue_pkg.sv
// fpu_issue_pkg: controller state encoding, operand/result word counts and watchdog limit
package fpu_issue_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_OPND, S_WAIT, S_RES} state_t;
  localparam logic [2:0] OPND_SP = 3'd2;
  localparam logic [2:0] OPND_DP = 3'd4;
  localparam logic [1:0] RES_SP = 2'd1;
  localparam logic [1:0] RES_DP = 2'd2;
  localparam logic [7:0] WDOG_LIMIT = 8'd255;
  function automatic logic [2:0] opnd_n(input logic dp);
    return dp ? OPND_DP : OPND_SP;
  endfunction
  function automatic logic [1:0] res_m(input logic dp);
    return dp ? RES_DP : RES_SP;
  endfunction
endpackage

// File: rtl/fpu_issue_wdog.sv
// fpu_issue_wdog: 8-bit result watchdog; i_clear zeroes, i_enable counts, o_expire flags the limit
module fpu_issue_wdog
  import fpu_issue_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);
  logic [7:0] r_cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_cnt <= '0;
    else if (i_clear) r_cnt <= '0;
    else if (i_enable) r_cnt <= r_cnt + 8'd1;
  assign o_expire = r_cnt == WDOG_LIMIT;
endmodule

// File: rtl/fpu_issue_ctl.sv
// fpu_issue_ctl: IU->FPU op issue (iu_fop_*, nx_*), operand (iu_opnd*/fpin*) and result (fpout*/iu_res*) transfer, kill and timeout (fpkill, fop_tmo)
module fpu_issue_ctl
  import fpu_issue_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        iu_fop_req,
  input  logic [7:0]  iu_fop_code,
  input  logic        iu_fop_dprec,
  output logic        iu_fop_ack,
  input  logic        iu_opnd_vld,
  input  logic [31:0] iu_opnd,
  output logic        iu_opnd_rdy,
  input  logic        iu_kill,
  input  logic        iu_res_stall,
  output logic [7:0]  nx_opcode,
  output logic        nx_fpop_valid,
  output logic        nx_dprec,
  input  logic        fpbusyn,
  output logic        fpin_vld,
  output logic [31:0] fpin,
  input  logic        fpout_vld,
  input  logic [31:0] fpout,
  output logic        fpkill,
  output logic        fpuhold,
  output logic        iu_res_vld,
  output logic [31:0] iu_res,
  output logic        fop_busy,
  output logic        fop_tmo
);
  state_t r_state;
  logic [7:0] r_code;
  logic [31:0] r_fpin, r_res;
  logic [2:0] r_opnd_cnt;
  logic [1:0] r_res_cnt;
  logic r_dprec, r_nx_vld, r_fpin_vld, r_res_vld, r_fpkill, r_tmo;
  logic w_act, w_accept, w_xfer, w_wr, w_res_in, w_expire, w_last_opnd, w_last_res;
  assign w_act = r_state != S_IDLE;
  assign w_accept = r_state == S_IDLE && iu_fop_req && fpbusyn && !iu_kill;
  assign w_xfer = r_state == S_OPND && iu_opnd_vld && !iu_res_stall && !iu_kill;
  assign w_wr = r_state == S_WAIT || r_state == S_RES;
  // results are forwarded even when the IU stalls: the FPU must not be dropped on a protocol slip
  assign w_res_in = w_wr && fpout_vld && !iu_kill;
  assign w_last_opnd = (r_opnd_cnt + 3'd1) == opnd_n(r_dprec);
  assign w_last_res = (r_res_cnt + 2'd1) == res_m(r_dprec);
  fpu_issue_wdog u_wdog (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (!w_wr || iu_kill),
    .i_enable (w_wr && !fpout_vld && !iu_res_stall),
    .o_expire (w_expire)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= S_IDLE;
      r_code <= '0;
      r_dprec <= 1'b0;
      r_nx_vld <= 1'b0;
      r_fpin_vld <= 1'b0;
      r_fpin <= '0;
      r_res_vld <= 1'b0;
      r_res <= '0;
      r_fpkill <= 1'b0;
      r_tmo <= 1'b0;
      r_opnd_cnt <= '0;
      r_res_cnt <= '0;
    end else begin
      r_nx_vld <= 1'b0;
      r_fpkill <= 1'b0;
      r_tmo <= 1'b0;
      r_fpin_vld <= w_xfer;
      if (w_xfer) r_fpin <= iu_opnd;
      r_res_vld <= w_res_in;
      if (w_res_in) r_res <= fpout;
      if (w_act && iu_kill) begin
        r_fpkill <= 1'b1;
        r_state <= S_IDLE;
        r_opnd_cnt <= '0;
        r_res_cnt <= '0;
      end else
        case (r_state)
          S_IDLE:
            if (w_accept) begin
              r_code <= iu_fop_code;
              r_dprec <= iu_fop_dprec;
              r_nx_vld <= 1'b1;
              r_state <= S_ISSUE;
            end
          S_ISSUE: begin
            r_opnd_cnt <= '0;
            r_state <= S_OPND;
          end
          S_OPND:
            if (w_xfer) begin
              r_opnd_cnt <= r_opnd_cnt + 3'd1;
              if (w_last_opnd) begin
                r_res_cnt <= '0;
                r_state <= S_WAIT;
              end
            end
          S_WAIT, S_RES:
            if (w_expire) begin
              r_tmo <= 1'b1;
              r_fpkill <= 1'b1;
              r_state <= S_IDLE;
            end else if (fpout_vld) begin
              r_res_cnt <= r_res_cnt + 2'd1;
              r_state <= w_last_res ? S_IDLE : S_RES;
            end
          default: r_state <= S_IDLE;
        endcase
    end
  assign iu_fop_ack = w_accept;
  assign iu_opnd_rdy = w_xfer;
  assign nx_opcode = r_code;
  assign nx_fpop_valid = r_nx_vld;
  assign nx_dprec = r_dprec;
  assign fpin_vld = r_fpin_vld;
  assign fpin = r_fpin;
  assign fpkill = r_fpkill;
  assign fpuhold = iu_res_stall;
  assign iu_res_vld = r_res_vld;
  assign iu_res = r_res;
  assign fop_busy = w_act;
  assign fop_tmo = r_tmo;
endmodule

// File: tb/tb_fpu_issue_ctl.sv
// tb_fpu_issue_ctl: randomized transaction-level check of fpu_issue_ctl
module tb_fpu_issue_ctl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic iu_fop_req = 1'b0;
  logic [7:0] iu_fop_code = '0;
  logic iu_fop_dprec = 1'b0;
  logic iu_fop_ack;
  logic iu_opnd_vld = 1'b0;
  logic [31:0] iu_opnd = '0;
  logic iu_opnd_rdy;
  logic iu_kill = 1'b0;
  logic iu_res_stall = 1'b0;
  logic [7:0] nx_opcode;
  logic nx_fpop_valid, nx_dprec;
  logic fpbusyn = 1'b1;
  logic fpin_vld;
  logic [31:0] fpin;
  logic fpout_vld = 1'b0;
  logic [31:0] fpout = '0;
  logic fpkill, fpuhold, iu_res_vld, fop_busy, fop_tmo;
  logic [31:0] iu_res;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  fpu_issue_ctl dut (
    .clk(clk), .reset(reset),
    .iu_fop_req(iu_fop_req), .iu_fop_code(iu_fop_code), .iu_fop_dprec(iu_fop_dprec), .iu_fop_ack(iu_fop_ack),
    .iu_opnd_vld(iu_opnd_vld), .iu_opnd(iu_opnd), .iu_opnd_rdy(iu_opnd_rdy),
    .iu_kill(iu_kill), .iu_res_stall(iu_res_stall),
    .nx_opcode(nx_opcode), .nx_fpop_valid(nx_fpop_valid), .nx_dprec(nx_dprec),
    .fpbusyn(fpbusyn), .fpin_vld(fpin_vld), .fpin(fpin),
    .fpout_vld(fpout_vld), .fpout(fpout),
    .fpkill(fpkill), .fpuhold(fpuhold),
    .iu_res_vld(iu_res_vld), .iu_res(iu_res), .fop_busy(fop_busy), .fop_tmo(fop_tmo)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // mode 0: normal results, 1: no results until timeout, 2: reset once in WAIT
  task automatic do_op(input logic dp, input logic [7:0] code, input logic [31:0] r0, input int busy_cyc,
                       input int stall_first, input int kill_at, input int mode);
    int n, m, sent, got, ns, done_at, idx;
    logic px, pr, kill, ov, fin;
    logic [31:0] pw, prw;
    n = dp ? 4 : 2;
    m = dp ? 2 : 1;
    iu_fop_req = 1'b1;
    iu_fop_code = code;
    iu_fop_dprec = dp;
    for (int i = 0; i < busy_cyc; i++) begin
      fpbusyn = 1'b0;
      @(negedge clk);
      chk("ack_while_busy", iu_fop_ack, 0);
      tick();
    end
    fpbusyn = 1'b1;
    @(negedge clk);
    chk("ack", iu_fop_ack, 1);
    chk("busy_idle", fop_busy, 0);
    tick();
    iu_fop_req = 1'b0;
    iu_fop_code = 8'($urandom);
    iu_fop_dprec = 1'($urandom);
    @(negedge clk);
    chk("nx_valid", nx_fpop_valid, 1);
    chk("nx_opcode", nx_opcode, code);
    chk("nx_dprec", nx_dprec, dp);
    chk("ack_pulse", iu_fop_ack, 0);
    chk("busy_issue", fop_busy, 1);
    tick();
    sent = 0; px = 0; pw = 0; idx = 0;
    while (sent < n && idx < 200) begin
      iu_opnd_vld = idx < stall_first ? 1'b1 : ($urandom_range(0, 3) != 0);
      iu_res_stall = idx < stall_first ? 1'b1 : ($urandom_range(0, 3) == 0);
      iu_opnd = $urandom;
      kill = sent == kill_at && iu_opnd_vld;
      iu_kill = kill;
      @(negedge clk);
      if (!kill) begin
        chk("opnd_rdy", iu_opnd_rdy, iu_opnd_vld & ~iu_res_stall);
        chk("fpin_vld", fpin_vld, px);
        if (px) chk("fpin", fpin, pw);
      end
      chk("nx_valid_low", nx_fpop_valid, 0);
      chk("fpuhold", fpuhold, iu_res_stall);
      chk("busy_opnd", fop_busy, 1);
      chk("fpkill_opnd", fpkill, 0);
      px = iu_opnd_vld & ~iu_res_stall & ~kill;
      pw = iu_opnd;
      if (px) sent++;
      idx++;
      tick();
      if (kill) begin
        iu_kill = 1'b0;
        iu_opnd_vld = 1'b0;
        iu_res_stall = 1'b0;
        @(negedge clk);
        chk("kill_fpkill", fpkill, 1);
        chk("kill_busy", fop_busy, 0);
        chk("kill_fpin_vld", fpin_vld, 0);
        tick();
        @(negedge clk);
        chk("kill_pulse", fpkill, 0);
        chk("kill_fpin_after", fpin_vld, 0);
        tick();
        return;
      end
    end
    iu_opnd_vld = 1'b0;
    if (sent < n) begin
      chk("opnd_bound", sent, n);
      return;
    end
    if (mode == 2) begin
      #2 reset = 1'b1;
      #1;
      chk("rst_busy", fop_busy, 0);
      chk("rst_fpin_vld", fpin_vld, 0);
      chk("rst_fpin", fpin, 0);
      chk("rst_fpkill", fpkill, 0);
      chk("rst_nx_opcode", nx_opcode, 0);
      chk("rst_res_vld", iu_res_vld, 0);
      chk("rst_tmo", fop_tmo, 0);
      @(negedge clk);
      reset = 1'b0;
      tick();
      @(negedge clk);
      chk("rst_after_fpkill", fpkill, 0);
      chk("rst_after_busy", fop_busy, 0);
      tick();
      return;
    end
    got = 0; pr = 0; prw = 0; ns = 0; done_at = -1; fin = 0;
    for (idx = 0; idx < 600; idx++) begin
      ov = mode == 0 && got < m && $urandom_range(0, 2) == 0;
      iu_res_stall = $urandom_range(0, 3) == 0;
      fpout_vld = ov;
      fpout = got == 0 ? r0 : $urandom;
      @(negedge clk);
      chk("fpin_vld_wait", fpin_vld, idx == 0 ? px : 1'b0);
      if (idx == 0 && px) chk("fpin_last", fpin, pw);
      chk("res_vld", iu_res_vld, pr);
      if (pr) chk("res", iu_res, prw);
      chk("fpuhold_wait", fpuhold, iu_res_stall);
      if (mode == 1) begin
        if (done_at >= 0 && idx == done_at + 2) begin
          chk("tmo", fop_tmo, 1);
          chk("tmo_fpkill", fpkill, 1);
          chk("tmo_busy", fop_busy, 0);
          fin = 1;
          break;
        end
        chk("tmo_early", fop_tmo, 0);
        chk("busy_wait", fop_busy, 1);
        if (!iu_res_stall) begin
          ns++;
          if (ns == 255) done_at = idx;
        end
      end else begin
        chk("busy_res", fop_busy, got < m);
        chk("tmo_none", fop_tmo, 0);
        chk("fpkill_none", fpkill, 0);
        if (got == m) begin
          fin = 1;
          break;
        end
      end
      pr = ov;
      prw = fpout;
      if (ov) got++;
      tick();
    end
    if (!fin) chk("result_bound", fin, 1);
    fpout_vld = 1'b0;
    iu_res_stall = 1'b0;
    tick();
    if (mode == 1) begin
      @(negedge clk);
      chk("tmo_pulse", fop_tmo, 0);
      chk("tmo_fpkill_pulse", fpkill, 0);
      tick();
    end
  endtask
  initial begin
    #12;
    chk("reset_ack", iu_fop_ack, 0);
    chk("reset_busy", fop_busy, 0);
    chk("reset_nx", {nx_fpop_valid, nx_dprec, nx_opcode}, 0);
    chk("reset_fpin", {fpin_vld, fpin}, 0);
    chk("reset_res", {iu_res_vld, iu_res}, 0);
    chk("reset_kill_tmo", {fpkill, fop_tmo, iu_opnd_rdy}, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    iu_fop_req = 1'b1;
    iu_kill = 1'b1;
    @(negedge clk);
    chk("kill_req_ack", iu_fop_ack, 0);
    tick();
    @(negedge clk);
    chk("kill_req_busy", fop_busy, 0);
    chk("kill_req_nx", nx_fpop_valid, 0);
    chk("kill_req_fpkill", fpkill, 0);
    tick();
    iu_fop_req = 1'b0;
    iu_kill = 1'b0;
    do_op(1'b0, 8'h62, 32'h3F800000, 0, 0, -1, 0);
    do_op(1'b1, 8'($urandom), $urandom, 0, 3, -1, 0);
    do_op(1'b0, 8'($urandom), $urandom, 5, 0, -1, 0);
    do_op(1'b0, 8'($urandom), $urandom, 0, 0, 1, 0);
    do_op(1'b1, 8'($urandom), $urandom, 1, 0, -1, 1);
    do_op(1'b0, 8'($urandom), $urandom, 0, 0, -1, 2);
    for (int k = 0; k < 40; k++)
      do_op(1'($urandom_range(0, 1)), 8'($urandom), $urandom, $urandom_range(0, 2), 0,
            $urandom_range(0, 4) == 0 ? int'($urandom_range(0, 3)) : -1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpu_issue_ctl.md
FPU_ISSUE_CTL -- requirements
Module: fpu_issue_ctl

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset; all ports are listed below as name, direction, width, meaning.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous active-high reset.
REQ-004 iu_fop_req / iu_fop_code / iu_fop_dprec  in  1/8/1  IU request, FP opcode, double-precision flag.
REQ-005 iu_fop_ack  out  1  one-cycle pulse: request accepted.
REQ-006 iu_opnd_vld / iu_opnd  in  1/32  IU operand word valid, operand data.
REQ-007 iu_opnd_rdy  out  1  operand word consumed this cycle.
REQ-008 iu_kill  in  1  abort current FP op; iu_res_stall  in  1  IU cannot accept a result word.
REQ-009 nx_opcode / nx_fpop_valid / nx_dprec  out  8/1/1  opcode issue to the FPU sequencer.
REQ-010 fpbusyn  in  1  FPU idle (high) / busy (low).
REQ-011 fpin_vld / fpin  out  1/32  operand word to the FPU.
REQ-012 fpout_vld / fpout  in  1/32  result word from the FPU.
REQ-013 fpkill / fpuhold  out  1/1  FPU abort pulse; FPU hold (equals iu_res_stall, combinational).
REQ-014 iu_res_vld / iu_res  out  1/32  result word to the IU; fop_busy out 1; fop_tmo out 1 (timeout pulse).

Function
REQ-015 The controller SHALL implement states IDLE, ISSUE, OPND, WAIT, RES.
REQ-016 IDLE: when iu_fop_req=1, fpbusyn=1 and iu_kill=0, it SHALL pulse iu_fop_ack, latch code/dprec, and enter ISSUE.
REQ-017 ISSUE (exactly one cycle): nx_fpop_valid=1, nx_opcode/nx_dprec = latched values; next state OPND.
REQ-018 OPND: operand count N = 4 if dprec else 2; a word transfers when iu_opnd_vld=1 and iu_res_stall=0: iu_opnd_rdy=1 combinationally; fpin/fpin_vld registered (1-cycle latency).
REQ-019 After the N-th transfer the state SHALL become WAIT; the operand counter is 3 bits and clears on entry to OPND.
REQ-020 WAIT/RES: result count M = 2 if dprec else 1; each fpout_vld word SHALL appear on iu_res with iu_res_vld one cycle later; after the M-th word the state returns to IDLE.
REQ-021 fpout_vld asserted while iu_res_stall=1 is an FPU protocol violation; the word SHALL still be forwarded (no drop).
REQ-022 Watchdog: 8-bit counter clears on entry to WAIT, increments each WAIT/RES cycle without fpout_vld and while iu_res_stall=0; at 255 the controller SHALL pulse fop_tmo and fpkill and return to IDLE.
REQ-023 iu_kill=1 in any non-IDLE state SHALL pulse fpkill next cycle, clear all counters, suppress fpin_vld/iu_res_vld that cycle, and force IDLE.
REQ-024 iu_kill and iu_fop_req together in IDLE: kill wins, no ack, no issue.
REQ-025 fop_busy SHALL be 1 in every state except IDLE.
REQ-026 Back-to-back ops SHALL be allowed: a new ack may occur the cycle after return to IDLE when fpbusyn=1.

Reset
REQ-027 On reset the state SHALL be IDLE and all counters zero; outputs iu_fop_ack, iu_opnd_rdy, nx_fpop_valid, nx_dprec, fpin_vld, iu_res_vld, fpkill, fop_tmo, fop_busy = 0; nx_opcode, fpin, iu_res = 0.
REQ-028 Reset asserted mid-operation SHALL abandon the op without an fpkill pulse (the FPU is reset by the same signal).

Structure
REQ-029 Package fpu_issue_pkg SHALL hold the state encoding, operand/result counts (2/4, 1/2) and watchdog limit (255).
REQ-030 The watchdog SHALL be a separate sub-module fpu_issue_wdog (clear, enable, expire output).

Verification
REQ-031 Single op 0x62, dprec=0, fpbusyn=1, 2 operands, 1 result 0x3F800000 -> ack at cycle 0, nx_fpop_valid cycle 1, iu_res=0x3F800000 one cycle after fpout_vld, IDLE after.
REQ-032 Double op, 4 operands with iu_res_stall=1 for 3 cycles in OPND -> no transfer while stalled, exactly 4 fpin_vld pulses, 2 iu_res_vld pulses.
REQ-033 iu_fop_req with fpbusyn=0 for 5 cycles -> no ack until fpbusyn=1.
REQ-034 iu_kill during 2nd operand -> fpkill single pulse, fop_busy=0 next cycle, no further fpin_vld.
REQ-035 WAIT with no fpout_vld for 255 cycles -> fop_tmo and fpkill pulse together, IDLE next cycle.
REQ-036 Reset asserted in WAIT -> all outputs zero immediately (asynchronous), no fpkill.
